axis_ch_pack: RTL

N-channel AXI-Stream packer: buffers ADC sample streams from NUM_CH independent sources, arbitrates round-robin between channels with a full burst available, and emits framed packets on a single AXI-Stream master toward the aurora channel inputs of the system top. It is the parametrised successor of the fixed two-input pack stage. It adds per-channel FIFOs, a channel/sequence header, tlast framing and sticky overflow reporting.

---
 rtl/axis_ch_pack.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/axis_ch_pack.sv
// N-channel AXI-Stream packer: per-channel FIFOs, round-robin burst arbitration, framed output packets.
// Optional header word (0xA5 / channel id / per-channel sequence) enabled by defining AXIS_CH_PACK_HDR_EN.
module axis_ch_pack #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int BURST_LEN  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     adc_start,
  input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]        s_axis_tvalid,
  output logic [NUM_CH-1:0]        s_axis_tready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic [NUM_CH-1:0]        overflow,
  input  logic                     overflow_clr
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  BURST_CNT = CNT_W'(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN);
  localparam logic [PTR_W-1:0]  PTR_MAX   = PTR_W'(FIFO_DEPTH - 1);

`ifdef AXIS_CH_PACK_HDR_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HDR = 2'd1, ST_PAY = 2'd2} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PAY = 2'd2} state_e;
`endif

  state_e                       state_q, state_d;
  logic [DATA_W-1:0]            mem_q [NUM_CH][FIFO_DEPTH];
  logic [NUM_CH-1:0][PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]            overflow_q, overflow_d;
  logic [NUM_CH-1:0]            wr_en_s, drop_s, pop_s, elig_s;
  logic [CH_W-1:0]              grant_q, grant_d, rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]              pick_s, rr_next_s, load_ch_s;
  logic                         found_s, load_word_s;
  logic [BEAT_W-1:0]            beat_q, beat_d;
  logic [DATA_W-1:0]            tdata_q, tdata_d;
  logic                         tvalid_q, tvalid_d, tlast_q, tlast_d;
`ifdef AXIS_CH_PACK_HDR_EN
  logic [NUM_CH-1:0][15:0]      seq_q, seq_d;

  function automatic logic [DATA_W-1:0] hdr_word(input logic [CH_W-1:0] ch, input logic [15:0] seq);
    hdr_word        = '0;
    hdr_word[31:24] = 8'hA5;
    hdr_word[23:16] = 8'(ch);
    hdr_word[15:0]  = seq;
  endfunction
`endif

  assign s_axis_tready = {NUM_CH{1'b1}};
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign overflow      = overflow_q;

  // FIFO bookkeeping: full check uses the pre-edge count, so a write to a full FIFO drops even during a pop
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      wr_en_s[c] = s_axis_tvalid[c] && adc_start && (cnt_q[c] != FULL_CNT);
      drop_s[c]  = s_axis_tvalid[c] && adc_start && (cnt_q[c] == FULL_CNT);
      pop_s[c]   = load_word_s && (load_ch_s == CH_W'(c));
      elig_s[c]  = (cnt_q[c] >= BURST_CNT);
      wr_ptr_d[c] = wr_en_s[c] ? ((wr_ptr_q[c] == PTR_MAX) ? '0 : wr_ptr_q[c] + PTR_W'(1)) : wr_ptr_q[c];
      rd_ptr_d[c] = pop_s[c] ? ((rd_ptr_q[c] == PTR_MAX) ? '0 : rd_ptr_q[c] + PTR_W'(1)) : rd_ptr_q[c];
      case ({wr_en_s[c], pop_s[c]})
        2'b10:   cnt_d[c] = cnt_q[c] + CNT_W'(1);
        2'b01:   cnt_d[c] = cnt_q[c] - CNT_W'(1);
        default: cnt_d[c] = cnt_q[c];
      endcase
    end
    overflow_d = (overflow_q & ~{NUM_CH{overflow_clr}}) | drop_s;
  end

  // Round-robin pick: first eligible channel at or above rr_ptr, wrapping
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found_s && elig_s[CH_W'((int'(rr_ptr_q) + i) % NUM_CH)]) begin
        found_s = 1'b1;
        pick_s  = CH_W'((int'(rr_ptr_q) + i) % NUM_CH);
      end else begin
        found_s = found_s;
      end
    end
    rr_next_s = CH_W'((int'(pick_s) + 1) % NUM_CH);
  end

  // Packet FSM and output register loading; every payload load pops the granted FIFO
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    beat_d      = beat_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    load_word_s = 1'b0;
    load_ch_s   = grant_q;
`ifdef AXIS_CH_PACK_HDR_EN
    seq_d       = seq_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (adc_start && found_s) begin
          grant_d   = pick_s;
          rr_ptr_d  = rr_next_s;
          load_ch_s = pick_s;
`ifdef AXIS_CH_PACK_HDR_EN
          tdata_d   = hdr_word(pick_s, seq_q[pick_s]);
          tvalid_d  = 1'b1;
          tlast_d   = 1'b0;
          state_d   = ST_HDR;
`else
          load_word_s = 1'b1;
          state_d     = ST_PAY;
`endif
        end else begin
          tvalid_d = 1'b0;
        end
      end
`ifdef AXIS_CH_PACK_HDR_EN
      ST_HDR: begin
        if (m_axis_tready) begin
          seq_d[grant_q] = seq_q[grant_q] + 16'd1;
          load_word_s    = 1'b1;
          state_d        = ST_PAY;
        end else begin
          state_d = ST_HDR;
        end
      end
`endif
      ST_PAY: begin
        if (m_axis_tready) begin
          if (tlast_q) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            beat_d   = '0;
            state_d  = ST_IDLE;
          end else begin
            load_word_s = 1'b1;
          end
        end else begin
          state_d = ST_PAY;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        beat_d   = '0;
      end
    endcase
    if (load_word_s) begin
      tdata_d  = mem_q[load_ch_s][rd_ptr_q[load_ch_s]];
      tvalid_d = 1'b1;
      beat_d   = beat_q + BEAT_W'(1);
      tlast_d  = ((beat_q + BEAT_W'(1)) == LAST_BEAT);
    end else begin
      beat_d = beat_d;
    end
  end

  // Control and output state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= '0;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_q     <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
`ifdef AXIS_CH_PACK_HDR_EN
      seq_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_q     <= beat_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
`ifdef AXIS_CH_PACK_HDR_EN
      seq_q      <= seq_d;
`endif
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clock) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_en_s[c]) begin
        mem_q[c][wr_ptr_q[c]] <= s_axis_tdata[c*DATA_W +: DATA_W];
      end
    end
  end

endmodule
